// File: rtl/wordle_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wordle_pkg : shared word geometry, colour codes and scorer state encoding.
// Rev 1.0
// ---------------------------------------------------------------------------
package wordle_pkg;

   localparam int WORD_LEN = 5;
   localparam int LETTER_W = 8;

   localparam logic [1:0] CLR_GREY   = 2'b00;
   localparam logic [1:0] CLR_YELLOW = 2'b01;
   localparam logic [1:0] CLR_GREEN  = 2'b10;
   localparam logic [1:0] CLR_EMPTY  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GREEN  = 2'd1,
      ST_YELLOW = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

endpackage
`default_nettype wire

// File: rtl/wordle_letter_match.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wordle_letter_match : finds the lowest unused answer position holding a letter.
// Rev 1.0
// ---------------------------------------------------------------------------
module wordle_letter_match
   import wordle_pkg::*;
#(
   parameter int WORD_LEN = wordle_pkg::WORD_LEN,
   parameter int LETTER_W = wordle_pkg::LETTER_W
) (
   input  logic [LETTER_W-1:0]          letter,
   input  logic [WORD_LEN*LETTER_W-1:0] answer,
   input  logic [WORD_LEN-1:0]          used,
   output logic                         hit,
   output logic [WORD_LEN-1:0]          j_sel
);

   always_comb begin
      hit   = 1'b0;
      j_sel = '0;
      for (int j = 0; j < WORD_LEN; j++) begin
         if (!hit && !used[j] &&
             (answer[(WORD_LEN-1-j)*LETTER_W +: LETTER_W] == letter)) begin
            hit      = 1'b1;
            j_sel[j] = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/wordle_scorer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wordle_scorer : multi-cycle green/yellow/grey scorer for one five-letter guess.
// Option macro WORDLE_DUP_AWARE_EN selects official duplicate-letter handling.
// Rev 1.0
// ---------------------------------------------------------------------------
module wordle_scorer
   import wordle_pkg::*;
#(
   parameter int WORD_LEN = wordle_pkg::WORD_LEN,
   parameter int LETTER_W = wordle_pkg::LETTER_W
) (
   input  logic                         Clk,
   input  logic                         reset_n,
   input  logic                         start,
   input  logic [WORD_LEN*LETTER_W-1:0] guess,
   input  logic [WORD_LEN*LETTER_W-1:0] answer,
   output logic                         busy,
   output logic                         done,
   output logic [2*WORD_LEN-1:0]        colors,
   output logic                         win
);

   localparam int IDX_W = $clog2(WORD_LEN);

   state_e                       state_q, state_d;
   logic [WORD_LEN*LETTER_W-1:0] guess_q, guess_d;
   logic [WORD_LEN*LETTER_W-1:0] answer_q, answer_d;
   logic [2*WORD_LEN-1:0]        colors_q, colors_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic                         win_q, win_d;
   logic [WORD_LEN-1:0]          used_q, used_d;

   logic [LETTER_W-1:0]          w_letter;
   logic [WORD_LEN-1:0]          w_used;
   logic                         w_hit;
   int                           w_slot;

   always_comb begin
      w_slot   = 2 * (WORD_LEN - 1 - int'(idx_q));
      w_letter = guess_q[(WORD_LEN-1-int'(idx_q))*LETTER_W +: LETTER_W];
   end

`ifdef WORDLE_DUP_AWARE_EN
   logic [WORD_LEN-1:0] w_j_sel;
   assign w_used = used_q;
`else
   logic [WORD_LEN-1:0] w_j_sel_unused;
   // Masking only the letter's own position turns the matcher into "any j != i".
   assign w_used = WORD_LEN'(1) << idx_q;
`endif

   wordle_letter_match #(
      .WORD_LEN (WORD_LEN),
      .LETTER_W (LETTER_W)
   ) u_match (
      .letter (w_letter),
      .answer (answer_q),
      .used   (w_used),
      .hit    (w_hit),
`ifdef WORDLE_DUP_AWARE_EN
      .j_sel  (w_j_sel)
`else
      .j_sel  (w_j_sel_unused)
`endif
   );

   always_comb begin
      state_d  = state_q;
      guess_d  = guess_q;
      answer_d = answer_q;
      colors_d = colors_q;
      idx_d    = idx_q;
      win_d    = win_q;
      used_d   = used_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_GREEN;
               guess_d  = guess;
               answer_d = answer;
               colors_d = {WORD_LEN{CLR_EMPTY}};
               used_d   = '0;
               win_d    = 1'b0;
            end
         end
         ST_GREEN: begin
            for (int k = 0; k < WORD_LEN; k++) begin
               if (guess_q[(WORD_LEN-1-k)*LETTER_W +: LETTER_W] ==
                   answer_q[(WORD_LEN-1-k)*LETTER_W +: LETTER_W]) begin
                  colors_d[2*(WORD_LEN-1-k) +: 2] = CLR_GREEN;
                  used_d[k]                       = 1'b1;
               end else begin
                  colors_d[2*(WORD_LEN-1-k) +: 2] = CLR_GREY;
               end
            end
            idx_d   = '0;
            state_d = ST_YELLOW;
         end
         ST_YELLOW: begin
            if ((colors_q[w_slot +: 2] != CLR_GREEN) && w_hit) begin
               colors_d[w_slot +: 2] = CLR_YELLOW;
`ifdef WORDLE_DUP_AWARE_EN
               used_d = used_q | w_j_sel;
`endif
            end
            if (idx_q == IDX_W'(WORD_LEN - 1)) begin
               state_d = ST_DONE;
               win_d   = (colors_d == {WORD_LEN{CLR_GREEN}});
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         guess_q  <= '0;
         answer_q <= '0;
         colors_q <= {WORD_LEN{CLR_EMPTY}};
         idx_q    <= '0;
         win_q    <= 1'b0;
         used_q   <= '0;
      end else begin
         state_q  <= state_d;
         guess_q  <= guess_d;
         answer_q <= answer_d;
         colors_q <= colors_d;
         idx_q    <= idx_d;
         win_q    <= win_d;
         used_q   <= used_d;
      end
   end

   assign busy   = (state_q != ST_IDLE);
   assign done   = (state_q == ST_DONE);
   assign colors = colors_q;
   assign win    = win_q;

endmodule
`default_nettype wire

// File: tb/tb_wordle_scorer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wordle_scorer : randomized self-checking bench with a word-level scoring model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_wordle_scorer;

   logic        Clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [39:0] guess;
   logic [39:0] answer;
   logic        busy;
   logic        done;
   logic [9:0]  colors;
   logic        win;

   int tests = 0;
   int fails = 0;

`ifdef WORDLE_DUP_AWARE_EN
   localparam bit DUP = 1'b1;
`else
   localparam bit DUP = 1'b0;
`endif

   wordle_scorer dut (
      .Clk     (Clk),
      .reset_n (reset_n),
      .start   (start),
      .guess   (guess),
      .answer  (answer),
      .busy    (busy),
      .done    (done),
      .colors  (colors),
      .win     (win)
   );

   always #5 Clk = ~Clk;

   // Word-level reference: greens first, then left-to-right yellows.
   function automatic logic [9:0] model(input logic [39:0] g, input logic [39:0] a, input bit dup);
      logic [7:0] gl [5];
      logic [7:0] al [5];
      bit         used [5];
      int         col [5];
      logic [9:0] r;
      for (int k = 0; k < 5; k++) begin
         gl[k]   = g[39-8*k -: 8];
         al[k]   = a[39-8*k -: 8];
         used[k] = 0;
         col[k]  = 0;
      end
      for (int k = 0; k < 5; k++)
         if (gl[k] == al[k]) begin col[k] = 2; used[k] = 1; end
      for (int i = 0; i < 5; i++) begin
         if (col[i] != 2) begin
            for (int j = 0; j < 5; j++) begin
               if (col[i] == 0 && gl[i] == al[j] && (dup ? !used[j] : (j != i))) begin
                  col[i] = 1;
                  if (dup) used[j] = 1;
               end
            end
         end
      end
      r = '0;
      for (int k = 0; k < 5; k++) r = (r << 2) | 10'(col[k]);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [39:0] rand_word();
      logic [39:0] w;
      for (int k = 0; k < 5; k++) w[39-8*k -: 8] = 8'h41 + 8'($urandom_range(0, 4));
      return w;
   endfunction

   // Runs one score; with disturb set, start and the inputs are scrambled while busy.
   task automatic run_score(input logic [39:0] g, input logic [39:0] a, input bit disturb);
      logic [9:0] exp_c;
      exp_c = model(g, a, DUP);
      @(negedge Clk);
      guess  = g;
      answer = a;
      start  = 1'b1;
      for (int n = 1; n <= 7; n++) begin
         @(negedge Clk);
         chk("busy_during", {31'd0, busy}, 32'd1);
         chk("done_timing", {31'd0, done}, {31'd0, (n == 7)});
         if (n == 7) begin
            chk("colors", {22'd0, colors}, {22'd0, exp_c});
            chk("win", {31'd0, win}, {31'd0, (exp_c == 10'h2AA)});
         end
         if (disturb && n < 7) begin
            start  = 1'($urandom_range(0, 1));
            guess  = rand_word();
            answer = rand_word();
         end else begin
            start = 1'b0;
         end
      end
      @(negedge Clk);
      chk("busy_after", {31'd0, busy}, 32'd0);
      chk("done_after", {31'd0, done}, 32'd0);
      chk("colors_hold", {22'd0, colors}, {22'd0, exp_c});
      chk("win_hold", {31'd0, win}, {31'd0, (exp_c == 10'h2AA)});
   endtask

   initial begin
      logic [39:0] g, a;
      reset_n = 1'b0;
      start   = 1'b0;
      guess   = '0;
      answer  = '0;
      repeat (2) @(negedge Clk);
      chk("rst_colors", {22'd0, colors}, 32'h3FF);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_win", {31'd0, win}, 32'd0);
      reset_n = 1'b1;

      // Hand-computed pins on the model itself.
      chk("model_crane", {22'd0, model("CRANE", "CRANE", DUP)}, 32'h2AA);
      chk("model_speed", {22'd0, model("SPEED", "ABIDE", DUP)}, DUP ? 32'h011 : 32'h015);
      chk("model_eerie", {22'd0, model("EERIE", "THERE", DUP)}, DUP ? 32'h112 : 32'h152);

      run_score("CRANE", "CRANE", 1'b0);
      chk("crane_lit", {22'd0, colors}, 32'h2AA);
      chk("crane_win", {31'd0, win}, 32'd1);
      run_score("SPEED", "ABIDE", 1'b0);
      chk("speed_lit", {22'd0, colors}, DUP ? 32'h011 : 32'h015);
      chk("speed_win", {31'd0, win}, 32'd0);
      run_score("EERIE", "THERE", 1'b1);
      chk("eerie_lit", {22'd0, colors}, DUP ? 32'h112 : 32'h152);

      // Reset sampled at E4 aborts the score with no done.
      @(negedge Clk);
      guess  = "CRANE";
      answer = "CRANE";
      start  = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         @(negedge Clk);
         start = 1'b0;
         if (n == 4) reset_n = 1'b0;
      end
      @(negedge Clk);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_colors", {22'd0, colors}, 32'h3FF);
      chk("abort_win", {31'd0, win}, 32'd0);
      reset_n = 1'b1;
      for (int n = 0; n < 8; n++) begin
         @(negedge Clk);
         chk("abort_no_done", {31'd0, done}, 32'd0);
      end
      run_score("EERIE", "THERE", 1'b0);

      for (int t = 0; t < 200; t++) begin
         g = rand_word();
         a = ($urandom_range(0, 7) == 0) ? g : rand_word();
         run_score(g, a, 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wordle_scorer.md
# wordle_scorer

Scores one five-letter guess against the hidden answer and produces per-letter colour codes (green/yellow/grey) plus a win flag. It sits between `wordle_sm`, which supplies `guessWord` and `randomWord` once the fifth letter is committed, and the VGA tile renderer, which consumes the colour vector. It is a multi-cycle FSM so that duplicate-letter rules match the official game.

## Interface
Parameters:
- `WORD_LEN`, 5: letters per word.
- `LETTER_W`, 8: bits per letter (ASCII). Letter 0 is the leftmost and sits in the MSBs.

Ports:
- `Clk`  in  1  system clock. One clock domain; reset is synchronous and active-low.
- `reset_n`  in  1  synchronous active-low reset.
- `start`  in  1  single-cycle request. Sampled only in IDLE.
- `guess`  in  40  guessed word; letter i occupies [39-8i : 32-8i].
- `answer`  in  40  hidden word, same packing.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse; `colors` and `win` are valid.
- `colors`  out  10  2 bits per letter; letter 0 occupies [9:8]. Codes: 00 grey, 01 yellow, 10 green, 11 empty.
- `win`  out  1  high when all five letters are green.

## Operation
- States and transitions:
  - IDLE → GREEN on `start`.
  - GREEN → YELLOW.
  - YELLOW loops with index i = 0..4. At i = 4 it moves to DONE.
  - DONE → IDLE.
- On start acceptance:
  - Latch `guess` and `answer` into internal registers. Later input changes are ignored.
  - Set `colors` to 10'h3FF.
  - Clear `used[4:0]`.
- GREEN (one cycle, all positions in parallel):
  - If g[k] == a[k], set colour k to green and set used[k].
  - Otherwise set colour k to grey.
- YELLOW, step i:
  - If letter i is already green, do nothing.
  - Otherwise find the lowest j with g[i] == a[j] and used[j] == 0.
  - If such a j exists, set colour i to yellow and set used[j].
  - If not, colour i stays grey.
- DONE:
  - Assert `done`.
  - `win` = (colors == 10'b1010101010).
- Output hold: `colors` and `win` hold their values until the next accepted `start`.
- Letters are compared as raw 8-bit values. No case folding.

## Timing
- Reset values: `busy`=0, `done`=0, `win`=0, `colors`=10'h3FF, state=IDLE.
- Clock-edge sequence:
  - Edge E0 samples `start`.
  - GREEN executes at E1.
  - YELLOW steps execute at E2..E6.
  - `done`=1 in the cycle following E6, for exactly one cycle. Fixed latency: start sampled → done = 7 cycles.
- `busy` is high from the cycle after E0 through the `done` cycle inclusive.
- `start` while `busy` is ignored: no restart and no queuing.
- `start` held high in IDLE starts a new score on each IDLE cycle. A back-to-back restart therefore happens on the cycle after the `done` cycle.
- Reset mid-operation: `reset_n`=0 at any edge returns all state and outputs to their reset values at that edge. No `done` is produced for the aborted score.
- Latency is identical for every input, including all-green words. Steps are not skipped.

## Configuration
- `WORDLE_DUP_AWARE_EN` defined:
  - Yellow search honours and updates `used[]`, giving exact official duplicate handling.
- `WORDLE_DUP_AWARE_EN` undefined:
  - A yellow is issued whenever g[i] matches any a[j] with j ≠ i.
  - `used[]` is neither checked nor updated for yellows. The register may be optimised out.
  - Latency and the interface are unchanged.

## Structure
- Shared package `wordle_pkg` holds:
  - constants `WORD_LEN` and `LETTER_W`;
  - colour codes `CLR_GREY`, `CLR_YELLOW`, `CLR_GREEN`, `CLR_EMPTY`;
  - the FSM state encoding, which the VGA and top-level debug string decode also use.
- One sub-module, `wordle_letter_match`. It is combinational:
  - inputs: one guess letter, the answer word, `used[4:0]`;
  - outputs: `hit` and a one-hot `j_sel[4:0]` for the lowest unused match.
  - The FSM instantiates it once, muxed by i.

## Test plan
- Reset with `reset_n`=0 → `colors`=10'h3FF, `busy`=0, `done`=0, `win`=0.
- guess "CRANE", answer "CRANE", `start` pulse → `done` exactly 7 cycles after the start sample, `colors`=10'h2AA, `win`=1.
- guess "SPEED", answer "ABIDE" → `colors`=10'h011, `win`=0. Without `WORDLE_DUP_AWARE_EN` → 10'h015.
- guess "EERIE", answer "THERE" → `colors`=10'h112. This checks that a green consumes the answer E and that the second E is grey.
- `start` re-pulsed during YELLOW, and inputs changed mid-score → ignored. Result still equals the first score, with a single `done` pulse.
- `reset_n` low at E4 → `busy`=0 and `colors`=10'h3FF at the next cycle, no `done`. A following `start` scores normally.
